// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of sigin in inclk cycles
// Ports:
//   inclk     - sole clock, all state on its rising edge
//   reset     - asynchronous active-high reset
//   sigin     - clock-like signal under measurement
//   clear     - synchronous re-arm, discards any partial measurement
//   period    - last completed period, rising edge to rising edge
//   high_time - inclk samples with sigin high within that period
//   valid     - one-cycle pulse when period/high_time update
//   stalled   - high while no rising edge seen for TIMEOUT_CYCLES
// Build option: define CLOCK_PERIOD_METER_SYNC_EN to pass sigin through a
// two-flop synchronizer (2 extra cycles of latency, same period values).
module clock_period_meter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        inclk,
    input  logic        reset,
    input  logic        sigin,
    input  logic        clear,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic        valid,
    output logic        stalled
);
    typedef enum logic [1:0] {ARM, MEASURE, STALLED} state_t;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [31:0] period_q, period_d, high_q, high_d;
    logic        valid_q, valid_d, stalled_q, stalled_d;
    logic        sig_s, sig_dly_q, rise;
`ifdef CLOCK_PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], sigin};
    end
    assign sig_s = sync_q[1];
`else
    assign sig_s = sigin;
`endif
    assign rise = sig_s & ~sig_dly_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        if (clear) begin
            state_d   = ARM;
            cnt_d     = '0;
            hcnt_d    = '0;
            period_d  = '0;
            high_d    = '0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    cnt_d  = rise ? 32'd1 : '0;
                    hcnt_d = rise ? 32'd1 : '0;
                    state_d = rise ? MEASURE : ARM;
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = 32'd1;
                        hcnt_d   = 32'd1;
                    end else if (cnt_q == TIMEOUT_CYCLES) begin
                        // counters freeze here; the next rise reloads them
                        state_d   = STALLED;
                        stalled_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 32'd1;
                        hcnt_d = hcnt_q + {31'd0, sig_s};
                    end
                end
                STALLED: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        cnt_d     = 32'd1;
                        hcnt_d    = 32'd1;
                        stalled_d = 1'b0;
                    end
                end
                default: state_d = ARM;
            endcase
        end
    end
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            sig_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
            sig_dly_q <= sig_s;
        end
    end
    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign stalled   = stalled_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed stimulus with a scoreboard queue and valid-driven monitor
module tb_clock_period_meter;
    localparam int TIMEOUT = 100;
`ifdef CLOCK_PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic        inclk = 1'b0;
    logic        reset = 1'b1;
    logic        sigin = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] period, high_time;
    logic        valid, stalled;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic        prev_b = 1'b0;
    logic        have_prev = 1'b0;
    int          since = 0;
    int          hsince = 0;
    clock_period_meter #(.TIMEOUT_CYCLES(32'(TIMEOUT))) dut (
        .inclk(inclk), .reset(reset), .sigin(sigin), .clear(clear),
        .period(period), .high_time(high_time), .valid(valid), .stalled(stalled)
    );
    always #5 inclk = ~inclk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask
    // Stimulus model: every rising edge of sigin closes the previous period unless
    // there was none or the gap exceeded the timeout (meter stalled meanwhile).
    task automatic drive_bit(input logic b);
        @(negedge inclk);
        sigin = b;
        if (b && !prev_b) begin
            if (have_prev && since <= TIMEOUT) exp_q.push_back({32'(since), 32'(hsince)});
            have_prev = 1'b1;
            since = 0;
            hsince = 0;
        end
        since++;
        hsince += int'(b);
        prev_b = b;
    endtask
    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) drive_bit(1'b1);
            repeat (lo) drive_bit(1'b0);
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_period"}, period, 32'd0);
        check({tag, "_high_time"}, high_time, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_stalled"}, {31'd0, stalled}, 32'd0);
    endtask
    always @(posedge inclk) begin
        #1;
        if (valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid period=%0d high_time=%0d", period, high_time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({period, high_time} !== e) begin
                    failures++;
                    $display("FAIL valid_data period=%0d high_time=%0d want %0d/%0d",
                             period, high_time, e[63:32], e[31:0]);
                end
            end
        end
    end
    initial begin
        repeat (3) @(negedge inclk);
        check_zero("reset");
        reset = 1'b0;
        wave(5, 5, 5);
        wave(3, 7, 4);
        wave(2, 2, 4);
        wave(1, 1, 6);
        // reset in the low phase of a 10-cycle wave
        wave(5, 5, 2);
        repeat (5) drive_bit(1'b1);
        repeat (2) drive_bit(1'b0);
        repeat (2 + LAT) @(negedge inclk);
        @(negedge inclk);
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge inclk);
        reset = 1'b0;
        have_prev = 1'b0;
        repeat (3) drive_bit(1'b0);
        wave(5, 5, 3);
        // exactly-timeout period is still measured, one more cycle stalls
        drive_bit(1'b1);
        repeat (99) drive_bit(1'b0);
        drive_bit(1'b1);
        for (int i = 1; i <= 110; i++) begin
            drive_bit(1'b0);
            if (i == 100 + LAT) check("stall_not_yet", {31'd0, stalled}, 32'd0);
            if (i == 101 + LAT) begin
                check("stall_set", {31'd0, stalled}, 32'd1);
                check("stall_period_kept", period, 32'd100);
                check("stall_high_kept", high_time, 32'd1);
            end
        end
        drive_bit(1'b1);
        repeat (4) drive_bit(1'b0);
        repeat (LAT) @(negedge inclk);
        check("stall_cleared", {31'd0, stalled}, 32'd0);
        wave(5, 5, 3);
        // clear coincident with the detected rise
        @(negedge inclk);
        sigin = 1'b1;
        prev_b = 1'b1;
        have_prev = 1'b0;
        repeat (LAT) @(negedge inclk);
        clear = 1'b1;
        @(negedge inclk);
        clear = 1'b0;
        check_zero("clear");
        repeat (3) drive_bit(1'b1);
        repeat (5) drive_bit(1'b0);
        wave(5, 5, 3);
        repeat (20) @(negedge inclk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_valids got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
